// File: rtl/spi_frame_pkg.sv
// spi_frame_pkg: frame engine state encoding and rw bit constants
package spi_frame_pkg;
  typedef logic [2:0] state_t;
  localparam state_t IDLE = 3'd0;
  localparam state_t CMD  = 3'd1;
  localparam state_t ADDR = 3'd2;
  localparam state_t DATA = 3'd3;
  localparam state_t DONE = 3'd4;
  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;
endpackage

// File: rtl/spi_reg_frame.sv
// spi_reg_frame: SPI mode-0 frame decoder producing register write/read strobes and MISO
module spi_reg_frame
  import spi_frame_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ena,
  input  logic              cs_n,
  input  logic              sclk_pos,
  input  logic              sclk_neg,
  input  logic              mosi,
  output logic              miso,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic              frame_err
);
  localparam int CW = $clog2((ADDR_W > DATA_W ? ADDR_W : DATA_W) + 1);
  localparam logic [CW-1:0] A_LAST = CW'(ADDR_W - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DATA_W - 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic rw;
  logic ld;
  logic [DATA_W-1:0] tx_sr;
  logic in_frame;
  assign in_frame = state == CMD || state == ADDR || state == DATA;
  assign miso = (state == DATA || state == DONE) && tx_sr[DATA_W-1];
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state     <= IDLE;
      cnt       <= '0;
      rw        <= 1'b0;
      ld        <= 1'b0;
      tx_sr     <= '0;
      addr      <= '0;
      wdata     <= '0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      frame_err <= 1'b0;
      // rdata load stays pending across ena=0 so a read request is never lost
      ld        <= rd_en | (ld & ~ena);
      if (ena) begin
        if (ld) tx_sr <= rdata;
        else if (sclk_neg && state == DATA && cnt != '0) tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
        if (cs_n && in_frame) begin
          state     <= IDLE;
          cnt       <= '0;
          frame_err <= 1'b1;
        end else begin
          case (state)
            IDLE: begin
              cnt <= '0;
              if (!cs_n) state <= CMD;
            end
            CMD: if (sclk_pos) begin
              rw    <= mosi;
              state <= ADDR;
            end
            ADDR: if (sclk_pos) begin
              addr <= {addr[ADDR_W-2:0], mosi};
              cnt  <= cnt == A_LAST ? '0 : cnt + 1'b1;
              if (cnt == A_LAST) begin
                state <= DATA;
                rd_en <= rw == RW_READ;
              end
            end
            DATA: if (sclk_pos) begin
              if (rw == RW_WRITE) wdata <= {wdata[DATA_W-2:0], mosi};
              cnt <= cnt + 1'b1;
              if (cnt == D_LAST) begin
                state <= DONE;
                wr_en <= rw == RW_WRITE;
              end
            end
            DONE: if (cs_n) state <= IDLE;
            default: state <= IDLE;
          endcase
        end
      end
    end
  end
endmodule

// File: doc/spi_reg_frame.md
Name: spi_reg_frame

Overview:
System-clock-domain SPI mode-0 peripheral frame engine. It sits directly downstream of the synchronizers and rising/falling edge detectors on SCLK. It consumes single-cycle sclk edge pulses, the synchronized CS and MOSI, and decodes each frame into one register write strobe or one register read request. For reads it serializes the returned data onto MISO.

Parameters:
ADDR_W, 4, register address width in bits.
DATA_W, 8, register data width in bits.

Ports:
clk  input  1  system clock; frame logic runs only on its rising edge.
rstb  input  1  reset, synchronous, active-low.
ena  input  1  clock enable; when low, all state holds and no pulses are issued.
cs_n  input  1  synchronized chip select, active-low.
sclk_pos  input  1  one-cycle pulse marking an SCLK rising edge (sample MOSI).
sclk_neg  input  1  one-cycle pulse marking an SCLK falling edge (shift MISO).
mosi  input  1  synchronized MOSI.
miso  output  1  serial read data, MSB first.
wr_en  output  1  one-cycle write strobe.
rd_en  output  1  one-cycle read request.
addr  output  ADDR_W  register address; valid while wr_en/rd_en is high and held until the next frame.
wdata  output  DATA_W  write data; valid with wr_en.
rdata  input  DATA_W  read data; must be valid the cycle after rd_en.
frame_err  output  1  one-cycle pulse when a frame is aborted early.

Behaviour:
- Reset: state IDLE, counters 0, shift registers 0; miso, wr_en, rd_en, frame_err are 0; addr and wdata are 0.
- Frame layout: 1 + ADDR_W + DATA_W bits, MSB first. Bit 0 is rw (1 = write). The ADDR_W address bits follow, then DATA_W data bits. Default frame is 13 bits.
- MOSI is sampled only on a cycle with sclk_pos=1 and cs_n=0.
- States and transitions:
  - IDLE: enter CMD when cs_n=0.
  - CMD: on sclk_pos, capture rw and go to ADDR.
  - ADDR: shift in ADDR_W bits. On the last bit, go to DATA. If rw=0, pulse rd_en on the next cycle, with addr valid.
  - DATA: the bit counter counts DATA_W sclk_pos pulses.
    - Write: shift mosi into wdata. On the cycle after the last bit, pulse wr_en once and go to DONE.
    - Read: go to DONE after DATA_W sclk_pos pulses.
  - DONE: ignore every further sclk pulse. Return to IDLE on cs_n=1.
- Read path:
  - tx shift register loads rdata on the cycle after rd_en.
  - miso = tx_sr MSB in DATA and DONE states, 0 otherwise.
  - tx_sr shifts left on sclk_neg only once at least one data bit has been sampled. The falling edge between the last address bit and the first data bit does not shift.
- Timing constraint: clk frequency ≥ 8 × SCLK frequency. This guarantees the load completes before the first data falling edge.
- Abort: cs_n=1 in CMD, ADDR or DATA sends the block to IDLE on the next cycle and pulses frame_err once. No wr_en is issued. A rd_en already issued is not retracted.
- Boundary conditions:
  - cs_n=1 in IDLE or DONE gives no frame_err.
  - sclk_pos and cs_n rising in the same cycle: abort wins and the bit is not sampled.
  - sclk_pos and sclk_neg high in the same cycle is illegal and need not be handled.
- ena=0 freezes all registers; pulses are not stretched.
- rstb low mid-frame: the reset values above apply on the next clk edge. No strobe is issued, including no frame_err.
- Counter width: $clog2(max(ADDR_W, DATA_W) + 1).

Decomposition:
- Package spi_frame_pkg holds the state enum (IDLE, CMD, ADDR, DATA, DONE) and the constants RW_WRITE=1 and RW_READ=0.
- No sub-module. The edge detectors and synchronizers are instantiated by the parent.

Test Plan:
- Write rw=1, addr=0x5, data=0xA3 over 13 sclk edges → exactly one wr_en pulse with addr=0x5 and wdata=0xA3, and no rd_en.
- Read rw=0, addr=0x2, with the bench returning rdata=0x3C one cycle after rd_en → one rd_en pulse with addr=0x2; MISO at each data sclk_pos reads 0,0,1,1,1,1,0,0.
- Raise cs_n after 6 sclk edges of a write → one frame_err pulse, no wr_en, state IDLE; the next full write frame decodes correctly.
- Write frame with 3 extra sclk edges before cs_n rises → a single wr_en, and wdata stays 0xA3.
- Drop rstb mid-ADDR, release it, then send a read frame of addr 0xF → the outputs show reset values, then one rd_en with addr=0xF.
- Toggle sclk pulses with cs_n=1, and hold ena=0 mid-frame for 20 cycles → no outputs change, and the frame completes correctly once ena=1.
